if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch_if.sv | 29 ++
 rtl/if_prefetch.sv | 141 ++++++++++++++
 tb/tb_if_prefetch.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_if.sv
// Instruction-memory bus between the prefetcher (master) and the memory (slave).
// Request channel is a valid/ready handshake; the response channel is valid-only
// and always returns words in request order.
interface if_prefetch_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  IMEM_req_valid;
   logic                  IMEM_req_ready;
   logic [ADDR_WIDTH-1:0] IMEM_req_addr;
   logic                  IMEM_rsp_valid;
   logic [DATA_WIDTH-1:0] IMEM_rsp_data;

   modport master (
      output IMEM_req_valid,
      output IMEM_req_addr,
      input  IMEM_req_ready,
      input  IMEM_rsp_valid,
      input  IMEM_rsp_data
   );

   modport slave (
      input  IMEM_req_valid,
      input  IMEM_req_addr,
      output IMEM_req_ready,
      output IMEM_rsp_valid,
      output IMEM_rsp_data
   );
endinterface

// File: rtl/if_prefetch.sv
// Instruction-fetch prefetcher: issues sequential word fetches under a credit
// limit so the prefetch FIFO can never overflow, tags each returned word with
// its PC, and presents the FIFO head to decode. A redirect flushes the FIFO,
// restarts fetching at the new target and discards every response still in
// flight at that point.
module if_prefetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  Clk_100MHz,
   input  logic                  Reset,
   input  logic                  MEM_PC_source_sel,
   input  logic [ADDR_WIDTH-1:0] MEM_PC_branch_dest,
   input  logic                  ID_ready,
   if_prefetch_if.master         imem,
   output logic                  IF_valid,
   output logic [ADDR_WIDTH-1:0] IF_PC,
   output logic [DATA_WIDTH-1:0] IF_Instruction
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W:0]        DEPTH_EXT  = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] START_PC   = RESET_PC & ALIGN_MASK;
   localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
   localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);

   logic [ADDR_WIDTH-1:0] fetchPc_q, fetchPc_d;
   logic [ADDR_WIDTH-1:0] rspPc_q, rspPc_d;
   logic [CNT_W-1:0]      outstanding_q, outstanding_d;
   logic [CNT_W-1:0]      dropCnt_q, dropCnt_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;

   logic [ADDR_WIDTH-1:0] pcMem    [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] instrMem [FIFO_DEPTH];

   logic [ADDR_WIDTH-1:0] redirectTarget;
   logic [CNT_W:0]        creditSum;
   logic                  reqValid;
   logic                  reqFire;
   logic                  dropping;
   logic                  push;
   logic                  pop;

   // Credit check, handshakes and next-state for all counters; a redirect wins over push and pop
   always_comb begin
      redirectTarget = MEM_PC_branch_dest & ALIGN_MASK;
      creditSum      = {1'b0, count_q} + {1'b0, outstanding_q};
      reqValid       = !Reset && !MEM_PC_source_sel && (creditSum < DEPTH_EXT);
      reqFire        = reqValid && imem.IMEM_req_ready;
      dropping       = (dropCnt_q != '0);
      push           = imem.IMEM_rsp_valid && !dropping && !MEM_PC_source_sel;
      pop            = (count_q != '0) && ID_ready && !MEM_PC_source_sel;

      fetchPc_d     = fetchPc_q;
      rspPc_d       = rspPc_q;
      dropCnt_d     = dropCnt_q;
      count_d       = count_q;
      rdPtr_d       = rdPtr_q;
      wrPtr_d       = wrPtr_q;
      outstanding_d = outstanding_q;

      if (reqFire) begin
         outstanding_d = outstanding_d + CNT_ONE;
      end
      if (imem.IMEM_rsp_valid) begin
         outstanding_d = outstanding_d - CNT_ONE;
      end

      if (MEM_PC_source_sel) begin
         fetchPc_d = redirectTarget;
         rspPc_d   = redirectTarget;
         count_d   = '0;
         rdPtr_d   = '0;
         wrPtr_d   = '0;
         dropCnt_d = outstanding_d;
      end else begin
         if (reqFire) begin
            fetchPc_d = fetchPc_q + WORD_STEP;
         end
         if (imem.IMEM_rsp_valid) begin
            if (dropping) begin
               dropCnt_d = dropCnt_q - CNT_ONE;
            end else begin
               rspPc_d = rspPc_q + WORD_STEP;
            end
         end
         if (push) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
         end
         count_d = count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
      end
   end

   // Control state registers with synchronous reset back to the start PC
   always_ff @(posedge Clk_100MHz) begin
      if (Reset) begin
         fetchPc_q     <= START_PC;
         rspPc_q       <= START_PC;
         outstanding_q <= '0;
         dropCnt_q     <= '0;
         count_q       <= '0;
         rdPtr_q       <= '0;
         wrPtr_q       <= '0;
      end else begin
         fetchPc_q     <= fetchPc_d;
         rspPc_q       <= rspPc_d;
         outstanding_q <= outstanding_d;
         dropCnt_q     <= dropCnt_d;
         count_q       <= count_d;
         rdPtr_q       <= rdPtr_d;
         wrPtr_q       <= wrPtr_d;
      end
   end

   // FIFO storage: each accepted response is written together with the PC it belongs to
   always_ff @(posedge Clk_100MHz) begin
      if (push && !Reset) begin
         pcMem[wrPtr_q]    <= rspPc_q;
         instrMem[wrPtr_q] <= imem.IMEM_rsp_data;
      end
   end

   assign imem.IMEM_req_valid = reqValid;
   assign imem.IMEM_req_addr  = fetchPc_q;

   assign IF_valid       = (count_q != '0) && !Reset;
   assign IF_PC          = pcMem[rdPtr_q];
   assign IF_Instruction = instrMem[rdPtr_q];

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch. A memory model with adjustable latency and random
// ready answers fetches in order with a per-address word. The reference model
// is the program-order stream: from the last reset/redirect target, decode must
// see PC, PC+4, PC+8 ... each with memWord(PC). The stimulus process loads that
// stream into the scoreboard whenever it restarts fetching; the monitor pops it
// on every delivered instruction.
module tb_if_prefetch;

   localparam int          ADDR_WIDTH = 32;
   localparam int          DATA_WIDTH = 32;
   localparam int          FIFO_DEPTH = 4;
   localparam logic [31:0] RESET_PC   = 32'h0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } expEntry_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } memReq_t;

   logic        clk = 1'b0;
   logic        Reset;
   logic        MEM_PC_source_sel;
   logic [31:0] MEM_PC_branch_dest;
   logic        ID_ready;
   logic        IF_valid;
   logic [31:0] IF_PC;
   logic [31:0] IF_Instruction;

   if_prefetch_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) imem ();

   if_prefetch #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH),
      .RESET_PC  (RESET_PC)
   ) dut (
      .Clk_100MHz        (clk),
      .Reset             (Reset),
      .MEM_PC_source_sel (MEM_PC_source_sel),
      .MEM_PC_branch_dest(MEM_PC_branch_dest),
      .ID_ready          (ID_ready),
      .imem              (imem),
      .IF_valid          (IF_valid),
      .IF_PC             (IF_PC),
      .IF_Instruction    (IF_Instruction)
   );

   always #5 clk = ~clk;

   int          testsRun    = 0;
   int          testsFailed = 0;
   expEntry_t   expQ[$];
   logic [31:0] expFetch    = RESET_PC;
   int          memLat      = 1;
   int          readyPct    = 100;
   int          idReadyPct  = 100;
   int          reqCount    = 0;
   logic [31:0] lastReqAddr = 32'h0;
   logic        sawZeroReq  = 1'b0;

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic loadExpected(input logic [31:0] start);
      logic [31:0] p;
      expQ.delete();
      for (int i = 0; i < 256; i++) begin
         p = start + 32'(4 * i);
         expQ.push_back('{pc: p, instr: memWord(p)});
      end
      expFetch = start;
   endtask

   // Drive reset/redirect for the next cycle; a restart reloads the expected stream
   task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] target);
      @(posedge clk);
      #1;
      Reset              = rst;
      MEM_PC_source_sel  = redir;
      MEM_PC_branch_dest = target;
      if (rst) begin
         loadExpected(RESET_PC);
      end else if (redir) begin
         loadExpected(target & ~32'h3);
      end
   endtask

   task automatic sampleCycle();
      @(negedge clk);
      #1;
   endtask

   task automatic waitNextReq(input string name, output logic ok);
      int base;
      base = reqCount;
      ok   = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         sampleCycle();
         if (reqCount != base) ok = 1'b1;
      end
      if (!ok) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s: got no request within 60 cycles, expected one", name);
      end
   endtask

   // Memory model: in-order responses after memLat cycles, random ready, random ID_ready
   initial begin : memModel
      memReq_t     pipe[$];
      int          cyc;
      logic        pendingReq;
      logic [31:0] pendingAddr;
      cyc         = 0;
      pendingReq  = 1'b0;
      pendingAddr = 32'h0;
      imem.IMEM_req_ready = 1'b0;
      imem.IMEM_rsp_valid = 1'b0;
      imem.IMEM_rsp_data  = 32'h0;
      ID_ready            = 1'b0;
      forever begin
         @(negedge clk);
         if (Reset) begin
            pipe.delete();
            pendingReq = 1'b0;
         end else begin
            if (imem.IMEM_req_valid) begin
               checkOutput("req addr aligned", {62'h0, imem.IMEM_req_addr[1:0]}, 64'h0);
            end
            if (pendingReq && !MEM_PC_source_sel) begin
               checkOutput("req valid held", {63'h0, imem.IMEM_req_valid}, 64'h1);
               checkOutput("req addr held", {32'h0, imem.IMEM_req_addr}, {32'h0, pendingAddr});
            end
            if (imem.IMEM_req_valid && imem.IMEM_req_ready) begin
               checkOutput("req addr", {32'h0, imem.IMEM_req_addr}, {32'h0, expFetch});
               expFetch    = expFetch + 32'h4;
               lastReqAddr = imem.IMEM_req_addr;
               if (imem.IMEM_req_addr == 32'h0) sawZeroReq = 1'b1;
               pipe.push_back('{addr: imem.IMEM_req_addr, due: cyc + memLat});
               reqCount++;
            end
            pendingReq  = imem.IMEM_req_valid && !imem.IMEM_req_ready;
            pendingAddr = imem.IMEM_req_addr;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            imem.IMEM_rsp_valid = 1'b1;
            imem.IMEM_rsp_data  = memWord(pipe[0].addr);
            void'(pipe.pop_front());
         end else begin
            imem.IMEM_rsp_valid = 1'b0;
            imem.IMEM_rsp_data  = $urandom;
         end
         imem.IMEM_req_ready = ($urandom_range(99) < readyPct);
         ID_ready            = ($urandom_range(99) < idReadyPct);
      end
   end

   // Monitor: compare every delivered instruction with the scoreboard head
   initial begin : monitor
      expEntry_t   e;
      logic        prevHold;
      logic        prevRedirect;
      logic [31:0] prevPc;
      logic [31:0] prevInstr;
      prevHold     = 1'b0;
      prevRedirect = 1'b0;
      prevPc       = 32'h0;
      prevInstr    = 32'h0;
      forever begin
         @(negedge clk);
         if (Reset) begin
            checkOutput("reset IF_valid", {63'h0, IF_valid}, 64'h0);
            checkOutput("reset req_valid", {63'h0, imem.IMEM_req_valid}, 64'h0);
            prevHold     = 1'b0;
            prevRedirect = 1'b0;
         end else begin
            if (prevRedirect) begin
               checkOutput("IF_valid after redirect", {63'h0, IF_valid}, 64'h0);
            end
            if (prevHold) begin
               checkOutput("stall IF_valid", {63'h0, IF_valid}, 64'h1);
               checkOutput("stall IF_PC", {32'h0, IF_PC}, {32'h0, prevPc});
               checkOutput("stall IF_Instruction", {32'h0, IF_Instruction}, {32'h0, prevInstr});
            end
            if (!MEM_PC_source_sel && IF_valid && ID_ready) begin
               if (expQ.size() == 0) begin
                  testsRun++;
                  testsFailed++;
                  $display("[TB] FAIL scoreboard underflow: got IF_PC %0h, expected no entry", IF_PC);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("IF_PC", {32'h0, IF_PC}, {32'h0, e.pc});
                  checkOutput("IF_Instruction", {32'h0, IF_Instruction}, {32'h0, e.instr});
               end
            end
            prevHold     = IF_valid && !ID_ready && !MEM_PC_source_sel;
            prevRedirect = MEM_PC_source_sel;
            prevPc       = IF_PC;
            prevInstr    = IF_Instruction;
         end
      end
   end

   // Directed scenarios followed by a randomized run
   initial begin : stimulus
      int   k;
      int   n;
      int   cnt;
      int   base;
      int   sinceRedir;
      logic ok;
      logic doRst;
      logic doRedir;
      Reset              = 1'b1;
      MEM_PC_source_sel  = 1'b0;
      MEM_PC_branch_dest = 32'h0;
      memLat             = 1;
      readyPct           = 100;
      idReadyPct         = 100;

      // Streaming from reset with a 1-cycle memory
      repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      k = 0;
      while (k < 20 && !(imem.IMEM_req_valid && imem.IMEM_req_ready)) begin
         sampleCycle();
         k++;
      end
      checkOutput("first req seen", {63'h0, imem.IMEM_req_valid && imem.IMEM_req_ready}, 64'h1);
      n = 0;
      do begin
         sampleCycle();
         n++;
      end while (!IF_valid && n < 10);
      checkOutput("req to IF_valid latency", 64'(n), 64'd2);
      cnt = 0;
      repeat (20) begin
         sampleCycle();
         if (IF_valid) cnt++;
      end
      checkOutput("one instr per cycle", 64'(cnt), 64'd20);

      // Decode stalled: exactly FIFO_DEPTH fetches, then resume at 0x10
      idReadyPct = 0;
      repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      base = reqCount;
      repeat (20) sampleCycle();
      checkOutput("stall request count", 64'(reqCount - base), 64'(FIFO_DEPTH));
      checkOutput("stall req_valid", {63'h0, imem.IMEM_req_valid}, 64'h0);
      checkOutput("stall head valid", {63'h0, IF_valid}, 64'h1);
      checkOutput("stall head PC", {32'h0, IF_PC}, {32'h0, RESET_PC});
      idReadyPct = 100;
      waitNextReq("resume request", ok);
      if (ok) checkOutput("resume address", {32'h0, lastReqAddr}, 64'h10);
      repeat (10) sampleCycle();

      // 3-cycle memory, redirect with responses in flight
      memLat = 3;
      repeat (10) sampleCycle();
      applyStimulus(1'b0, 1'b1, 32'h100);
      applyStimulus(1'b0, 1'b0, 32'h0);
      n = 0;
      while (!IF_valid && n < 30) begin
         sampleCycle();
         n++;
      end
      checkOutput("redirect 0x100 IF_valid", {63'h0, IF_valid}, 64'h1);
      checkOutput("redirect 0x100 first PC", {32'h0, IF_PC}, 64'h100);

      // Redirect to an unaligned target while a response arrives that cycle
      memLat = 1;
      repeat (8) sampleCycle();
      applyStimulus(1'b0, 1'b1, 32'h203);
      sampleCycle();
      checkOutput("rsp during redirect", {63'h0, imem.IMEM_rsp_valid}, 64'h1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      waitNextReq("post-redirect request", ok);
      if (ok) checkOutput("post-redirect address", {32'h0, lastReqAddr}, 64'h200);
      repeat (10) sampleCycle();

      // Fetch address wrap at the top of the address space
      memLat     = 2;
      readyPct   = 70;
      idReadyPct = 70;
      sawZeroReq = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      repeat (40) sampleCycle();
      checkOutput("wrap to 0 requested", {63'h0, sawZeroReq}, 64'h1);

      // Reset with a full FIFO aborts everything
      readyPct   = 100;
      idReadyPct = 0;
      repeat (15) sampleCycle();
      checkOutput("full before reset", {63'h0, IF_valid}, 64'h1);
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      sampleCycle();
      checkOutput("IF_valid in reset", {63'h0, IF_valid}, 64'h0);
      checkOutput("req_valid in reset", {63'h0, imem.IMEM_req_valid}, 64'h0);
      idReadyPct = 100;
      applyStimulus(1'b0, 1'b0, 32'h0);
      waitNextReq("post-reset request", ok);
      if (ok) checkOutput("post-reset address", {32'h0, lastReqAddr}, {32'h0, RESET_PC});

      // Randomized traffic with redirects and occasional resets
      sinceRedir = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 100 == 0) memLat = $urandom_range(1, 4);
         if (c % 50 == 0) begin
            readyPct   = $urandom_range(30, 100);
            idReadyPct = $urandom_range(30, 100);
         end
         doRst   = ($urandom_range(999) < 5);
         doRedir = ($urandom_range(99) < 3) || (sinceRedir > 150);
         applyStimulus(doRst, doRedir, $urandom);
         if (doRst || doRedir) sinceRedir = 0;
         else sinceRedir++;
      end
      applyStimulus(1'b0, 1'b0, 32'h0);
      repeat (5) sampleCycle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
      $fatal(1, "[TB] timeout");
   end

endmodule
